sca_frame_sender: RTL and testbench

SCA_FRAME_SENDER -- requirements
Module: sca_frame_sender

---
 rtl/sca_frame_sender.sv | 125 ++++++++++++
 tb/tb_sca_frame_sender.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sca_frame_sender.sv
// ---------------------------------------------------------------------------
// sca_frame_sender
//
// Serialises a parallel frame onto a two-wire link (sca_clk / sca_data) for a
// downstream shift register. That register samples sca_data on the falling
// edge of sca_clk. Bits go out MSB first. Each bit is held for one sca_clk
// period of 2*CLK_DIV M_CLK_OSC cycles: CLK_DIV cycles high, then CLK_DIV low.
//
// Parameters
//   DATA_LEN  frame length in bits (2..1024)
//   CLK_DIV   M_CLK_OSC cycles per sca_clk half-period (2..255)
//
// Ports
//   M_CLK_OSC  in   sole clock, rising-edge
//   reset      in   synchronous active-high reset
//   start      in   transmit request, only looked at while idle
//   frame      in   parallel frame, captured when start is accepted
//   busy       out  high while a frame is in flight
//   done       out  one-cycle pulse when a frame completes
//   sca_data   out  serial data
//   sca_clk    out  serial clock (idles high)
// ---------------------------------------------------------------------------
module sca_frame_sender #(
   parameter int DATA_LEN = 24,
   parameter int CLK_DIV  = 8
) (
   input  logic                M_CLK_OSC,
   input  logic                reset,
   input  logic                start,
   input  logic [DATA_LEN-1:0] frame,
   output logic                busy,
   output logic                done,
   output logic                sca_data,
   output logic                sca_clk
);

   localparam int PH_W = $clog2(CLK_DIV);
   localparam int BC_W = $clog2(DATA_LEN);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

   state_t              state_reg, state_next;
   logic [PH_W-1:0]     phase_reg, phase_next;
   logic [BC_W-1:0]     bit_cnt_reg, bit_cnt_next;
   logic [DATA_LEN-1:0] shift_reg, shift_next;
   logic                phase_last;
   logic                in_flight_next;

   assign phase_last = (phase_reg == PH_W'(CLK_DIV - 1));

   // Next-state logic. The phase counter restarts from zero on every state
   // entry, so each HIGH and each LOW lasts exactly CLK_DIV cycles.
   always_comb begin
      state_next   = state_reg;
      phase_next   = phase_reg + 1'b1;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      case (state_reg)
         IDLE: begin
            phase_next = '0;
            if (start) begin
               shift_next   = frame;
               bit_cnt_next = BC_W'(DATA_LEN - 1);
               state_next   = HIGH;
            end
         end
         HIGH: begin
            if (phase_last) begin
               phase_next = '0;
               state_next = LOW;
            end
         end
         LOW: begin
            if (phase_last) begin
               phase_next = '0;
               if (bit_cnt_reg == '0) begin
                  state_next = DONE;
               end else begin
                  // The shift happens on the same edge that sca_clk rises.
                  // So sca_data can only change together with a rising edge.
                  shift_next   = {shift_reg[DATA_LEN-2:0], 1'b0};
                  bit_cnt_next = bit_cnt_reg - 1'b1;
                  state_next   = HIGH;
               end
            end
         end
         DONE: begin
            phase_next = '0;
            state_next = IDLE;
         end
         default: begin
            phase_next = '0;
            state_next = IDLE;
         end
      endcase
   end

   assign in_flight_next = (state_next == HIGH) || (state_next == LOW);

   // The outputs are decoded from the next state and then registered.
   // This keeps the pins glitch-free, and they line up with the state they
   // describe.
   always_ff @(posedge M_CLK_OSC) begin
      if (reset) begin
         state_reg   <= IDLE;
         phase_reg   <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         sca_clk     <= 1'b1;
         sca_data    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_reg   <= state_next;
         phase_reg   <= phase_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         sca_clk     <= (state_next != LOW);
         sca_data    <= in_flight_next ? shift_next[DATA_LEN-1] : 1'b0;
         busy        <= in_flight_next;
         done        <= (state_next == DONE);
      end
   end

endmodule

// File: tb/tb_sca_frame_sender.sv
// ---------------------------------------------------------------------------
// tb_sca_frame_sender
//
// Directed bench for sca_frame_sender. It uses two instances:
//   u_dut       CLK_DIV=4, for the latency, back-to-back, ignored-start and
//               abort cases
//   u_dut_fast  CLK_DIV=2, for a run of random frames
//
// One monitor follows the selected instance. It does three things:
//   - it acts as the downstream shift register and shifts sca_data in on
//     every sca_clk falling edge
//   - it checks that sca_data is stable around each falling edge
//   - it notes the cycle numbers of busy and done
// Cycle numbering: the edge that samples start is cycle 0, so the first
// sample taken after that edge is cycle 1.
// ---------------------------------------------------------------------------
module tb_sca_frame_sender;

   localparam int DLEN = 24;

   logic            M_CLK_OSC = 1'b0;
   logic            reset;
   logic            start1, start2;
   logic [DLEN-1:0] frame;
   logic            busy1, done1, sca_data1, sca_clk1;
   logic            busy2, done2, sca_data2, sca_clk2;

   sca_frame_sender #(.DATA_LEN(DLEN), .CLK_DIV(4)) u_dut (
      .M_CLK_OSC (M_CLK_OSC),
      .reset     (reset),
      .start     (start1),
      .frame     (frame),
      .busy      (busy1),
      .done      (done1),
      .sca_data  (sca_data1),
      .sca_clk   (sca_clk1)
   );

   sca_frame_sender #(.DATA_LEN(DLEN), .CLK_DIV(2)) u_dut_fast (
      .M_CLK_OSC (M_CLK_OSC),
      .reset     (reset),
      .start     (start2),
      .frame     (frame),
      .busy      (busy2),
      .done      (done2),
      .sca_data  (sca_data2),
      .sca_clk   (sca_clk2)
   );

   always #5 M_CLK_OSC = ~M_CLK_OSC;

   // Monitor selection
   logic sel;
   int   cdiv;
   logic m_clk, m_data, m_busy, m_done;
   assign m_clk  = sel ? sca_clk2  : sca_clk1;
   assign m_data = sel ? sca_data2 : sca_data1;
   assign m_busy = sel ? busy2     : busy1;
   assign m_done = sel ? done2     : done1;

   // Monitor state
   int              cyc, fall_cnt, done_cnt, rise_cnt, viol;
   int              busy_first, busy_last, last_change, last_fall;
   int              done_at[2], fall_at[2], rise_at[2];
   logic [DLEN-1:0] rx, rx_at[2];
   logic            prev_clk, prev_data, prev_busy;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic mon_clear();
      cyc = 0; fall_cnt = 0; done_cnt = 0; rise_cnt = 0;
      busy_first = -1; busy_last = -1;
      last_change = -1000; last_fall = -1000;
      for (int i = 0; i < 2; i++) begin
         done_at[i] = -1; fall_at[i] = -1; rise_at[i] = -1; rx_at[i] = '0;
      end
      rx = '0;
      prev_clk = m_clk; prev_data = m_data; prev_busy = m_busy;
   endtask

   task automatic step();
      @(posedge M_CLK_OSC);
      #1;
      cyc++;
      if (m_data !== prev_data) begin
         if (cyc - last_fall < cdiv) viol++;
         last_change = cyc;
      end
      if (prev_clk && !m_clk) begin
         if (cyc - last_change < cdiv) viol++;
         last_fall = cyc;
         fall_cnt++;
         rx = {rx[DLEN-2:0], m_data};
      end
      if (m_busy && !prev_busy) begin
         if (rise_cnt < 2) rise_at[rise_cnt] = cyc;
         rise_cnt++;
      end
      if (m_busy) begin
         if (busy_first < 0) busy_first = cyc;
         busy_last = cyc;
      end
      if (m_done) begin
         if (done_cnt < 2) begin
            done_at[done_cnt] = cyc;
            fall_at[done_cnt] = fall_cnt;
            rx_at[done_cnt]   = rx;
         end
         done_cnt++;
         fall_cnt = 0;
      end
      prev_clk = m_clk; prev_data = m_data; prev_busy = m_busy;
   endtask

   task automatic run_until(input int ndone, input int bound);
      int k;
      k = 0;
      while (done_cnt < ndone && k < bound) begin
         step();
         k++;
      end
      chk("timeout", 32'(done_cnt >= ndone), 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      logic [DLEN-1:0] f;
      int k;
      sel = 1'b0; cdiv = 4; viol = 0;
      reset = 1'b1; start1 = 1'b0; start2 = 1'b0; frame = '0;
      mon_clear();
      idle(3);
      reset = 1'b0;
      idle(1);

      // Reset state of both instances
      chk("rst_clk",  32'(sca_clk1),  32'd1);
      chk("rst_data", 32'(sca_data1), 32'd0);
      chk("rst_busy", 32'(busy1),     32'd0);
      chk("rst_done", 32'(done1),     32'd0);
      chk("rst_fast", 32'({sca_clk2, sca_data2, busy2, done2}), 32'b1000);
      $display("tx reset: outputs idle");

      // Single frame: latency, busy window, bits received
      mon_clear();
      frame = 24'h0003A5; start1 = 1'b1;
      step();
      start1 = 1'b0;
      run_until(1, 400);
      idle(4);
      chk("single_rx",    32'(rx_at[0]),   32'h0003A5);
      chk("single_falls", 32'(fall_at[0]), 32'd24);
      chk("single_bfirst", 32'(busy_first), 32'd1);
      chk("single_blast", 32'(busy_last),  32'd192);
      chk("single_done",  32'(done_at[0]), 32'd193);
      chk("single_ndone", 32'(done_cnt),   32'd1);
      $display("tx single: rx=%h done@%0d", rx_at[0], done_at[0]);

      // Back-to-back with start held high
      mon_clear();
      frame = 24'hFFFFFF; start1 = 1'b1;
      step();
      frame = 24'h000001;
      run_until(2, 900);
      start1 = 1'b0;
      idle(4);
      chk("b2b_rx0",    32'(rx_at[0]),   32'hFFFFFF);
      chk("b2b_rx1",    32'(rx_at[1]),   32'h000001);
      chk("b2b_falls0", 32'(fall_at[0]), 32'd24);
      chk("b2b_falls1", 32'(fall_at[1]), 32'd24);
      chk("b2b_done0",  32'(done_at[0]), 32'd193);
      chk("b2b_done1",  32'(done_at[1]), 32'd387);
      chk("b2b_rise1",  32'(rise_at[1]), 32'd195);
      $display("tx b2b: rx0=%h rx1=%h done@%0d,%0d", rx_at[0], rx_at[1], done_at[0], done_at[1]);

      // start while busy and frame changes after the latch are both ignored
      mon_clear();
      frame = 24'h5A5A5A; start1 = 1'b1;
      step();
      start1 = 1'b0;
      k = 0;
      while (done_cnt < 1 && k < 400) begin
         if (cyc == 4) frame = 24'h123456;
         start1 = (cyc == 9 || cyc == 99);
         step();
         k++;
      end
      start1 = 1'b0;
      chk("ign_timeout", 32'(done_cnt), 32'd1);
      idle(4);
      chk("ign_rx",    32'(rx_at[0]),  32'h5A5A5A);
      chk("ign_done",  32'(done_at[0]), 32'd193);
      chk("ign_rises", 32'(rise_cnt),  32'd1);
      chk("ign_blast", 32'(busy_last), 32'd192);
      $display("tx ignore: rx=%h done@%0d", rx_at[0], done_at[0]);

      // Reset in the middle of a frame
      mon_clear();
      frame = 24'hABCDEF; start1 = 1'b1;
      step();
      start1 = 1'b0;
      while (cyc < 50) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_clk",  32'(m_clk),  32'd1);
      chk("abort_busy", 32'(m_busy), 32'd0);
      chk("abort_data", 32'(m_data), 32'd0);
      while (cyc < 59) step();
      chk("abort_falls", 32'(fall_cnt), 32'd6);
      chk("abort_ndone", 32'(done_cnt), 32'd0);
      $display("tx abort: falls=%0d", fall_cnt);
      mon_clear();
      frame = 24'hC3A50F; start1 = 1'b1;
      step();
      start1 = 1'b0;
      run_until(1, 400);
      chk("restart_rx",    32'(rx_at[0]),   32'hC3A50F);
      chk("restart_falls", 32'(fall_at[0]), 32'd24);
      chk("restart_done",  32'(done_at[0]), 32'd193);
      $display("tx restart: rx=%h done@%0d", rx_at[0], done_at[0]);
      idle(3);

      // Random frames on the CLK_DIV=2 instance
      sel = 1'b1; cdiv = 2;
      idle(2);
      for (int n = 0; n < 100; n++) begin
         mon_clear();
         f = DLEN'($urandom);
         frame = f; start2 = 1'b1;
         step();
         start2 = 1'b0;
         frame = ~f;
         run_until(1, 200);
         chk("rand_rx",    32'(rx_at[0]),   32'(f));
         chk("rand_falls", 32'(fall_at[0]), 32'd24);
         chk("rand_done",  32'(done_at[0]), 32'd97);
         $display("tx rand %0d: frame=%h rx=%h", n, f, rx_at[0]);
         idle(2);
      end

      chk("timing_viol", 32'(viol), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
